gpio_pio_avalon: RTL and testbench

Parametrised general-purpose I/O port on an Avalon-MM slave, and the next generation of the fixed 8-bit LED output port. It adds per-bit direction control, atomic bit set/clear, a 2-FF input synchroniser, edge capture and a maskable level interrupt. It sits in the Qsys system between the Nios II data master and board pins (LEDs, switches, keys, headers).

---
 rtl/gpio_pio_avalon.sv | 153 +++++++++++++++
 tb/tb_gpio_pio_avalon.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pio_avalon.sv
// ---------------------------------------------------------------------------
// gpio_pio_avalon
// Parametrised general-purpose I/O port on an Avalon-MM slave. Successor of
// the fixed 8-bit LED output port: adds per-bit direction, atomic set/clear,
// a 2-FF input synchroniser, edge capture and a maskable level interrupt.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   i_address     word address of the register (0..7)
//   i_chipselect  slave select
//   i_write_n     active-low write strobe
//   i_writedata   write data, bits above WIDTH-1 ignored
//   o_readdata    combinational read data, zero-extended
//   i_in_port     asynchronous pin inputs
//   o_out_port    output data register
//   o_oe          direction register (1 = output), pad output enable
//   o_irq         active-high level interrupt
//
// Register map
//   0 DATA  1 DIRECTION  2 IRQ_MASK  3 EDGE_CAPTURE (write 1 to clear)
//   4 OUTSET  5 OUTCLEAR  6,7 reserved
// ---------------------------------------------------------------------------
module gpio_pio_avalon #(
   parameter int              WIDTH      = 8,
   parameter logic [WIDTH-1:0] DATA_RESET = '0,
   parameter logic [WIDTH-1:0] DIR_RESET  = '1,
   parameter int              EDGE_TYPE  = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       i_address,
   input  logic             i_chipselect,
   input  logic             i_write_n,
   input  logic [31:0]      i_writedata,
   output logic [31:0]      o_readdata,
   input  logic [WIDTH-1:0] i_in_port,
   output logic [WIDTH-1:0] o_out_port,
   output logic [WIDTH-1:0] o_oe,
   output logic             o_irq
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_DIR      = 3'd1;
   localparam logic [2:0] ADDR_MASK     = 3'd2;
   localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

   logic [WIDTH-1:0] r_dataOut;
   logic [WIDTH-1:0] r_dir;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_capture;
   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_sync3;
   logic [1:0]       r_warm;

   logic             w_write;
   logic [WIDTH-1:0] w_wd;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_edge;
   logic             w_armed;
   logic [WIDTH-1:0] w_rdval;

   assign w_write = i_chipselect & ~i_write_n;
   assign w_wd    = WIDTH'(i_writedata);
   assign w_clr   = (w_write && (i_address == ADDR_CAPTURE)) ? w_wd : '0;
   assign w_armed = (r_warm == 2'd3);

   // Pin synchroniser. s1/s2 form the metastability chain; s3 is one extra
   // stage of history so the edge detector compares two settled samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_sync3 <= '0;
      end else begin
         r_sync1 <= i_in_port;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   // Warm-up counter. The synchroniser resets to zero, so pins that are
   // already high at reset release look like rising edges; capture stays
   // disarmed until those have flushed through the chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_warm <= 2'd0;
      end else if (r_warm != 2'd3) begin
         r_warm <= r_warm + 2'd1;
      end
   end

   // Edge selection is fixed at elaboration time by EDGE_TYPE.
   always_comb begin
      w_edge = r_sync2 & ~r_sync3;
      if (EDGE_TYPE == 1) begin
         w_edge = ~r_sync2 & r_sync3;
      end else if (EDGE_TYPE == 2) begin
         w_edge = r_sync2 ^ r_sync3;
      end
   end

   // Edge capture. The set term is ORed in after the clear so that an edge
   // arriving in the same cycle as a write-1-to-clear is not lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_capture <= '0;
      end else begin
         r_capture <= (r_capture & ~w_clr) | (w_armed ? w_edge : '0);
      end
   end

   // Software-visible control registers. OUTSET/OUTCLEAR give the CPU an
   // atomic way to touch single output bits without read-modify-write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dataOut <= DATA_RESET;
         r_dir     <= DIR_RESET;
         r_mask    <= '0;
      end else if (w_write) begin
         case (i_address)
            ADDR_DATA:     r_dataOut <= w_wd;
            ADDR_DIR:      r_dir     <= w_wd;
            ADDR_MASK:     r_mask    <= w_wd;
            ADDR_OUTSET:   r_dataOut <= r_dataOut | w_wd;
            ADDR_OUTCLEAR: r_dataOut <= r_dataOut & ~w_wd;
            default:       ;
         endcase
      end
   end

   // Zero-wait-state read mux. DATA shows the driven value on output bits
   // and the synchronised pin on input bits.
   always_comb begin
      w_rdval = '0;
      case (i_address)
         ADDR_DATA:    w_rdval = (r_dir & r_dataOut) | (~r_dir & r_sync2);
         ADDR_DIR:     w_rdval = r_dir;
         ADDR_MASK:    w_rdval = r_mask;
         ADDR_CAPTURE: w_rdval = r_capture;
         default:      w_rdval = '0;
      endcase
   end

   assign o_readdata = 32'(w_rdval);
   assign o_out_port = r_dataOut;
   assign o_oe       = r_dir;
   assign o_irq      = |(r_capture & r_mask);

endmodule

// File: tb/tb_gpio_pio_avalon.sv
// ---------------------------------------------------------------------------
// tb_gpio_pio_avalon
// Self-checking bench for gpio_pio_avalon (WIDTH=8, rising-edge capture).
// A reference model keeps the history of pin samples per clock edge and
// derives synchronised values, edges and capture bits from that history.
// ---------------------------------------------------------------------------
module tb_gpio_pio_avalon;

   localparam int         WIDTH      = 8;
   localparam logic [7:0] DATA_RESET = 8'h00;
   localparam logic [7:0] DIR_RESET  = 8'hFF;
   localparam int         EDGE_TYPE  = 0;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic [7:0]  out_port;
   logic [7:0]  oe;
   logic        irq;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model state
   logic [7:0] mData;
   logic [7:0] mDir;
   logic [7:0] mMask;
   logic [7:0] mCap;
   logic [7:0] pinHist[$];
   int         edgeN;

   always #5 clk = ~clk;

   gpio_pio_avalon #(
      .WIDTH     (WIDTH),
      .DATA_RESET(DATA_RESET),
      .DIR_RESET (DIR_RESET),
      .EDGE_TYPE (EDGE_TYPE)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_address   (address),
      .i_chipselect(chipselect),
      .i_write_n   (write_n),
      .i_writedata (writedata),
      .o_readdata  (readdata),
      .i_in_port   (in_port),
      .o_out_port  (out_port),
      .o_oe        (oe),
      .o_irq       (irq)
   );

   // Pin value sampled at clock edge k since reset release (edge 1 is the
   // first); before any sample the synchroniser holds zero.
   function automatic logic [7:0] pinAt(int k);
      if (k < 1 || k > pinHist.size()) return 8'h00;
      return pinHist[k-1];
   endfunction

   // Expected register read after the latest edge. The synchronised pin
   // value lags the pin sample by one edge.
   function automatic logic [31:0] expRead(logic [2:0] a);
      logic [7:0] inSync;
      inSync = pinAt(edgeN - 1);
      case (a)
         3'd0:    return {24'h0, (mDir & mData) | (~mDir & inSync)};
         3'd1:    return {24'h0, mDir};
         3'd2:    return {24'h0, mMask};
         3'd3:    return {24'h0, mCap};
         default: return 32'h0;
      endcase
   endfunction

   task automatic modelReset();
      mData = DATA_RESET;
      mDir  = DIR_RESET;
      mMask = 8'h00;
      mCap  = 8'h00;
      pinHist.delete();
      edgeN = 0;
   endtask

   // One clock edge: advance the model with the bus/pin values the DUT
   // samples at this edge, then return at the following falling edge.
   task automatic tick();
      logic [7:0] older;
      logic [7:0] oldest;
      logic [7:0] ev;
      logic [7:0] clr;
      logic [7:0] wd;
      logic       isWrite;
      int         n;
      @(posedge clk);
      n       = edgeN + 1;
      older   = pinAt(n - 2);
      oldest  = pinAt(n - 3);
      if (EDGE_TYPE == 1)      ev = ~older & oldest;
      else if (EDGE_TYPE == 2) ev = older ^ oldest;
      else                     ev = older & ~oldest;
      wd      = writedata[7:0];
      isWrite = chipselect && !write_n;
      clr     = (isWrite && address == 3'd3) ? wd : 8'h00;
      mCap    = (mCap & ~clr) | ((n >= 4) ? ev : 8'h00);
      if (isWrite) begin
         case (address)
            3'd0: mData = wd;
            3'd1: mDir  = wd;
            3'd2: mMask = wd;
            3'd4: mData = mData | wd;
            3'd5: mData = mData & ~wd;
            default: ;
         endcase
      end
      pinHist.push_back(in_port);
      edgeN = n;
      @(negedge clk);
   endtask

   task automatic busWrite(logic [2:0] a, logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic doReset(logic [7:0] pins);
      chipselect = 1'b0;
      write_n    = 1'b1;
      in_port    = pins;
      reset_n    = 1'b0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] exp;
      doReset(8'h00);
      if (out_port !== 8'h00) begin
         testsFailed++; $display("[TB] FAIL reset_out_port: got %h expected %h", out_port, 8'h00);
      end
      testsRun++;
      if (oe !== 8'hFF) begin
         testsFailed++; $display("[TB] FAIL reset_oe: got %h expected %h", oe, 8'hFF);
      end
      testsRun++;
      if (irq !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL reset_irq: got %b expected 0", irq);
      end
      testsRun++;
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         #1;
         exp = (a == 1) ? 32'h0000_00FF : 32'h0;
         if (readdata !== exp) begin
            testsFailed++; $display("[TB] FAIL reset_read_addr%0d: got %h expected %h", a, readdata, exp);
         end
         testsRun++;
         tick();
      end
   endtask

   task automatic test_atomic();
      busWrite(3'd0, 32'h0000_00A5);
      if (out_port !== 8'hA5) begin
         testsFailed++; $display("[TB] FAIL atomic_write: got %h expected %h", out_port, 8'hA5);
      end
      testsRun++;
      busWrite(3'd4, 32'h0000_000F);
      if (out_port !== 8'hAF) begin
         testsFailed++; $display("[TB] FAIL atomic_outset: got %h expected %h", out_port, 8'hAF);
      end
      testsRun++;
      busWrite(3'd5, 32'hFFFF_FF81);
      if (out_port !== 8'h2E) begin
         testsFailed++; $display("[TB] FAIL atomic_outclear: got %h expected %h", out_port, 8'h2E);
      end
      testsRun++;
      address = 3'd4;
      #1;
      if (readdata !== 32'h0) begin
         testsFailed++; $display("[TB] FAIL atomic_read_outset: got %h expected 0", readdata);
      end
      testsRun++;
   endtask

   task automatic test_direction();
      busWrite(3'd1, 32'h0000_00F0);
      busWrite(3'd0, 32'h0000_00FF);
      in_port = 8'h05;
      tick();
      tick();
      address = 3'd0;
      #1;
      if (readdata !== 32'h0000_00F5) begin
         testsFailed++; $display("[TB] FAIL dir_data_read: got %h expected %h", readdata, 32'hF5);
      end
      testsRun++;
      if (oe !== 8'hF0) begin
         testsFailed++; $display("[TB] FAIL dir_oe: got %h expected %h", oe, 8'hF0);
      end
      testsRun++;
   endtask

   task automatic test_edge_irq();
      in_port = 8'h00;
      tick(); tick(); tick();
      busWrite(3'd3, 32'h0000_00FF);
      busWrite(3'd2, 32'h0000_0001);
      in_port = 8'h01;
      address = 3'd3;
      tick();
      tick();
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL edge_early: got cap %h irq %b expected cap 0 irq 0", readdata, irq);
      end
      testsRun++;
      tick();
      if (readdata !== 32'h01) begin
         testsFailed++; $display("[TB] FAIL edge_capture: got %h expected %h", readdata, 32'h01);
      end
      testsRun++;
      if (irq !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL edge_irq: got %b expected 1", irq);
      end
      testsRun++;
      busWrite(3'd3, 32'h0000_0001);
      address = 3'd3;
      #1;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL edge_clear: got cap %h irq %b expected cap 0 irq 0", readdata, irq);
      end
      testsRun++;
      in_port = 8'h00;
      tick(); tick(); tick(); tick();
      if (readdata !== 32'h0) begin
         testsFailed++; $display("[TB] FAIL edge_falling_ignored: got %h expected 0", readdata);
      end
      testsRun++;
      in_port = 8'h01;
      tick(); tick(); tick();
      busWrite(3'd2, 32'h0000_0000);
      address = 3'd3;
      #1;
      if (irq !== 1'b0 || readdata !== 32'h01) begin
         testsFailed++; $display("[TB] FAIL mask_off: got irq %b cap %h expected irq 0 cap 01", irq, readdata);
      end
      testsRun++;
      busWrite(3'd3, 32'h0000_00FF);
   endtask

   task automatic test_collision();
      in_port = 8'h05;
      tick();
      tick();
      busWrite(3'd3, 32'h0000_0004);
      address = 3'd3;
      #1;
      if (readdata !== 32'h04) begin
         testsFailed++; $display("[TB] FAIL collision_set_wins: got %h expected %h", readdata, 32'h04);
      end
      testsRun++;
      busWrite(3'd3, 32'h0000_0004);
      address = 3'd3;
      #1;
      if (readdata !== 32'h0) begin
         testsFailed++; $display("[TB] FAIL collision_later_clear: got %h expected 0", readdata);
      end
      testsRun++;
   endtask

   task automatic test_random();
      logic [31:0] exp;
      logic [2:0]  rdAddr;
      for (int i = 0; i < 400; i++) begin
         chipselect = ($urandom_range(0, 1) == 1);
         write_n    = ($urandom_range(0, 2) == 0);
         address    = 3'($urandom_range(0, 7));
         writedata  = $urandom;
         if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
         tick();
         chipselect = 1'b0;
         write_n    = 1'b1;
         if (out_port !== mData) begin
            testsFailed++; $display("[TB] FAIL rand_out_port cycle %0d: got %h expected %h", i, out_port, mData);
         end
         testsRun++;
         if (oe !== mDir) begin
            testsFailed++; $display("[TB] FAIL rand_oe cycle %0d: got %h expected %h", i, oe, mDir);
         end
         testsRun++;
         if (irq !== (|(mCap & mMask))) begin
            testsFailed++; $display("[TB] FAIL rand_irq cycle %0d: got %b expected %b", i, irq, |(mCap & mMask));
         end
         testsRun++;
         rdAddr  = 3'($urandom_range(0, 7));
         address = rdAddr;
         #1;
         exp = expRead(rdAddr);
         if (readdata !== exp) begin
            testsFailed++; $display("[TB] FAIL rand_read addr %0d cycle %0d: got %h expected %h", rdAddr, i, readdata, exp);
         end
         testsRun++;
      end
   endtask

   task automatic test_warmup();
      doReset(8'hFF);
      address = 3'd3;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (readdata !== 32'h0 || readdata !== expRead(3'd3)) begin
            testsFailed++; $display("[TB] FAIL warmup_capture cycle %0d: got %h expected 0", i, readdata);
         end
         testsRun++;
      end
   endtask

   task automatic test_async_reset();
      busWrite(3'd0, 32'h0000_003C);
      busWrite(3'd2, 32'h0000_0001);
      in_port = 8'hFE;
      tick(); tick(); tick();
      in_port = 8'hFF;
      tick(); tick(); tick();
      if (irq !== 1'b1 || out_port !== 8'h3C) begin
         testsFailed++; $display("[TB] FAIL async_precondition: got irq %b out %h expected irq 1 out 3c", irq, out_port);
      end
      testsRun++;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      if (irq !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL async_irq: got %b expected 0", irq);
      end
      testsRun++;
      if (out_port !== DATA_RESET || oe !== DIR_RESET) begin
         testsFailed++; $display("[TB] FAIL async_regs: got out %h oe %h expected out %h oe %h", out_port, oe, DATA_RESET, DIR_RESET);
      end
      testsRun++;
      doReset(8'h00);
      tick();
      address = 3'd2;
      #1;
      if (readdata !== 32'h0) begin
         testsFailed++; $display("[TB] FAIL async_mask_cleared: got %h expected 0", readdata);
      end
      testsRun++;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      in_port    = 8'h00;
      modelReset();
      test_reset();
      test_atomic();
      test_direction();
      test_edge_irq();
      test_collision();
      test_random();
      test_warmup();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
